dac_frame_sequencer: RTL

//  Sequences telemetry words from a double-buffered frame RAM onto the two 8-bit DAC ports
//  (DAC1/DAC2 data + shared DAC clock), one word pair per word_tick strobe (640 kHz tick, clk80 domain).

---
 rtl/dac_frame_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/dac_frame_sequencer.sv
// dac_frame_sequencer
// Plays telemetry word pairs from a double-buffered frame RAM onto two 8-bit DAC
// buses with a shared latch clock, one word per word_tick. Also drives the
// frame-base marker and arbitrates bank swaps with the frame writer.
//
// Ports
//   clk80       system clock, rising edge
//   reset       asynchronous active-low reset
//   enable      playout enable (level)
//   word_tick   one-cycle strobe requesting the next word pair
//   rd_addr     frame RAM read address {bank, word_cnt}
//   rd_data     RAM read data (latency 1); low half -> DAC1, high half -> DAC2
//   swap_req    writer bank-swap request (level, held until swap_ack)
//   swap_ack    one-cycle pulse when the bank toggles
//   dac1_data   DAC1 data bus
//   dac2_data   DAC2 data bus
//   dac_clk     shared DAC latch clock
//   frame_mark  high while one of the leading words of a frame is on the buses
//   word_idx    index of the word currently on the buses
//   tick_lost   sticky flag: a tick arrived while a word was still in progress
module dac_frame_sequencer #(
    parameter int unsigned WORDS_PER_FRAME = 128,
    parameter int unsigned ADDR_W          = 7,
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned CLK_HI_CYCLES   = 4,
    parameter int unsigned MARK_WORDS      = 1
) (
    input  logic                  clk80,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  word_tick,
    output logic [ADDR_W:0]       rd_addr,
    input  logic [2*DATA_W-1:0]   rd_data,
    input  logic                  swap_req,
    output logic                  swap_ack,
    output logic [DATA_W-1:0]     dac1_data,
    output logic [DATA_W-1:0]     dac2_data,
    output logic                  dac_clk,
    output logic                  frame_mark,
    output logic [ADDR_W-1:0]     word_idx,
    output logic                  tick_lost
);

    localparam int unsigned CNT_W = $clog2(CLK_HI_CYCLES + 1);
    localparam logic [CNT_W-1:0]  HI_LAST   = CNT_W'(CLK_HI_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS_PER_FRAME - 1);
    localparam logic [ADDR_W:0]   MARK_LIM  = (ADDR_W + 1)'(MARK_WORDS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_STROBE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  hi_cnt;
    logic [ADDR_W-1:0] word_cnt;
    logic              bank;

    logic capture_c;
    logic last_c;
    logic clk_hi_nxt_c;
    logic wrap_c;
    logic swap_c;
    logic lost_c;
    logic idle_clear_c;

    assign rd_addr = {bank, word_cnt};

    // State register
    always_ff @(posedge clk80 or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (word_tick && enable) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_STROBE;
            S_STROBE: if (hi_cnt == HI_LAST) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Control decode. STROBE lasts CLK_HI_CYCLES+1 cycles: the first is the
    // data setup cycle, dac_clk is high for the remaining ones.
    always_comb begin
        capture_c    = 1'b0;
        last_c       = 1'b0;
        clk_hi_nxt_c = 1'b0;
        wrap_c       = 1'b0;
        swap_c       = 1'b0;
        lost_c       = 1'b0;
        idle_clear_c = 1'b0;
        case (state)
            S_IDLE: begin
                idle_clear_c = !enable;
                // swap_ack high means the writer has not yet seen the last ack
                swap_c       = !enable && swap_req && !swap_ack;
            end
            S_FETCH: begin
                capture_c = 1'b1;
                lost_c    = word_tick;
            end
            S_STROBE: begin
                last_c       = (hi_cnt == HI_LAST);
                clk_hi_nxt_c = !last_c;
                wrap_c       = last_c && (word_cnt == LAST_WORD);
                swap_c       = wrap_c && swap_req;
                lost_c       = word_tick;
            end
            default: ;
        endcase
    end

    // Strobe-length counter
    always_ff @(posedge clk80 or negedge reset) begin
        if (!reset) begin
            hi_cnt <= '0;
        end else if (state == S_STROBE && !last_c) begin
            hi_cnt <= hi_cnt + CNT_W'(1);
        end else begin
            hi_cnt <= '0;
        end
    end

    // Word counter and bank select
    always_ff @(posedge clk80 or negedge reset) begin
        if (!reset) begin
            word_cnt <= '0;
            bank     <= 1'b0;
            swap_ack <= 1'b0;
        end else begin
            if (last_c) begin
                word_cnt <= wrap_c ? '0 : word_cnt + ADDR_W'(1);
            end else if (idle_clear_c) begin
                word_cnt <= '0;
            end
            if (swap_c) begin
                bank <= ~bank;
            end
            swap_ack <= swap_c;
        end
    end

    // DAC output registers
    always_ff @(posedge clk80 or negedge reset) begin
        if (!reset) begin
            dac1_data  <= '0;
            dac2_data  <= '0;
            word_idx   <= '0;
            frame_mark <= 1'b0;
            dac_clk    <= 1'b0;
            tick_lost  <= 1'b0;
        end else begin
            if (capture_c) begin
                dac1_data  <= rd_data[DATA_W-1:0];
                dac2_data  <= rd_data[2*DATA_W-1:DATA_W];
                word_idx   <= word_cnt;
                frame_mark <= ({1'b0, word_cnt} < MARK_LIM);
            end
            dac_clk <= clk_hi_nxt_c;
            if (lost_c) begin
                tick_lost <= 1'b1;
            end
        end
    end

endmodule
